// File: rtl/game_pkg.sv
// game_pkg: phase encodings, widths and score helpers shared by the
// sequencer, the game datapath and the LED logic.
package game_pkg;

    localparam int STATE_W       = 3;
    localparam int SCORE_W       = 7;
    localparam int FRAME_W       = 8;
    localparam int SCORE_MAX_DEF = 99;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DEAD  = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // Increment that sticks at the ceiling instead of wrapping.
    function automatic logic [SCORE_W-1:0] score_inc(
        input logic [SCORE_W-1:0] value,
        input logic [SCORE_W-1:0] ceiling
    );
        return (value >= ceiling) ? ceiling : value + SCORE_W'(1);
    endfunction

    function automatic logic [SCORE_W-1:0] score_best(
        input logic [SCORE_W-1:0] a,
        input logic [SCORE_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// edge_pulse: registers a level (optionally inverted to active-high)
// and flags the inactive->active transition of the registered copy.
module edge_pulse #(
    parameter bit ACT_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic cur;
    logic prev;

    // Two-stage history of the active-high level; reset reads as inactive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur  <= 1'b0;
            prev <= 1'b0;
        end else begin
            cur  <= level ^ ACT_LOW;
            prev <= cur;
        end
    end

    // Driven only from registers, so downstream logic sees no input path.
    assign rise = cur & ~prev;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: frame tick, game-phase FSM, flap gating and score
// keeping for the Flappy Bird top level.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned READY_FRAMES = 30,
    parameter int unsigned HOLD_FRAMES  = 60,
    parameter int unsigned SCORE_MAX    = SCORE_MAX_DEF,
    parameter bit          VS_ACT_LOW   = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               key_press,
    input  logic               collision,
    input  logic               pipe_pass,
    output logic               frame_tick,
    output logic               world_rst,
    output logic               world_run,
    output logic               flap,
    output logic [STATE_W-1:0] state,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hi_score
);

    localparam logic [FRAME_W-1:0] READY_LAST = FRAME_W'(READY_FRAMES);
    localparam logic [FRAME_W-1:0] HOLD_LAST  = FRAME_W'(HOLD_FRAMES);
    localparam logic [SCORE_W-1:0] SCORE_TOP  = SCORE_W'(SCORE_MAX);

    state_t             phase;
    logic               tick;
    logic               press;
    logic               pending;
    logic [FRAME_W-1:0] frames;
    logic [FRAME_W-1:0] frames_inc;

    edge_pulse #(
        .ACT_LOW (VS_ACT_LOW)
    ) u_vs (
        .clk   (clk),
        .rst_n (rst_n),
        .level (vsync),
        .rise  (tick)
    );

    edge_pulse #(
        .ACT_LOW (1'b0)
    ) u_key (
        .clk   (clk),
        .rst_n (rst_n),
        .level (key_press),
        .rise  (press)
    );

    assign frames_inc = frames + FRAME_W'(1);
    assign state      = phase;

    // Phase FSM with registered pulses; tick feeds both frame_tick and
    // flap on the same edge so the two outputs line up.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase      <= ST_IDLE;
            score      <= '0;
            hi_score   <= '0;
            frames     <= '0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            world_rst  <= 1'b0;
            world_run  <= 1'b0;
            flap       <= 1'b0;
        end else begin
            frame_tick <= tick;
            world_rst  <= 1'b0;
            flap       <= 1'b0;
            unique case (phase)
                ST_IDLE, ST_OVER: begin
                    if (press) begin
                        phase     <= ST_READY;
                        world_rst <= 1'b1;
                        score     <= '0;
                        frames    <= '0;
                    end
                end
                ST_READY: begin
                    if (tick) begin
                        frames <= frames_inc;
                        if (frames_inc == READY_LAST) begin
                            phase     <= ST_PLAY;
                            world_run <= 1'b1;
                            pending   <= 1'b0;
                        end
                    end
                end
                ST_PLAY: begin
                    if (collision) begin
                        phase     <= ST_DEAD;
                        world_run <= 1'b0;
                        pending   <= 1'b0;
                        frames    <= '0;
                        hi_score  <= score_best(hi_score, score);
                    end else begin
                        if (pipe_pass) begin
                            score <= score_inc(score, SCORE_TOP);
                        end
                        if (tick) begin
                            flap    <= pending | press;
                            pending <= 1'b0;
                        end else if (press) begin
                            pending <= 1'b1;
                        end
                    end
                end
                ST_DEAD: begin
                    if (tick) begin
                        frames <= frames_inc;
                        if (frames_inc == HOLD_LAST) begin
                            phase <= ST_OVER;
                        end
                    end
                end
                default: begin
                    phase     <= ST_IDLE;
                    world_run <= 1'b0;
                    pending   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: scenario tasks with randomized stimulus checked
// against a phase-level reference model of the sequencer.
module tb_game_sequencer;

    localparam int RF = 30;
    localparam int HF = 60;
    localparam int SM = 99;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vsync = 1'b1;
    logic key_press = 1'b0;
    logic collision = 1'b0;
    logic pipe_pass = 1'b0;
    logic zero = 1'b0;
    logic vsync_hi;

    logic       frame_tick, world_rst, world_run, flap;
    logic [2:0] state;
    logic [6:0] score, hi_score;

    logic       p_tick, p_rst, p_run, p_flap;
    logic [2:0] p_state;
    logic [6:0] p_score, p_hi;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int frame_len = 20;
    int act_cyc = -1;

    always #10 clk = ~clk;

    assign vsync_hi = ~vsync;

    game_sequencer #(
        .READY_FRAMES (RF),
        .HOLD_FRAMES  (HF),
        .SCORE_MAX    (SM),
        .VS_ACT_LOW   (1'b1)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .key_press  (key_press),
        .collision  (collision),
        .pipe_pass  (pipe_pass),
        .frame_tick (frame_tick),
        .world_rst  (world_rst),
        .world_run  (world_run),
        .flap       (flap),
        .state      (state),
        .score      (score),
        .hi_score   (hi_score)
    );

    game_sequencer #(
        .READY_FRAMES (RF),
        .HOLD_FRAMES  (HF),
        .SCORE_MAX    (SM),
        .VS_ACT_LOW   (1'b0)
    ) u_pol (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync_hi),
        .key_press  (zero),
        .collision  (zero),
        .pipe_pass  (zero),
        .frame_tick (p_tick),
        .world_rst  (p_rst),
        .world_run  (p_run),
        .flap       (p_flap),
        .state      (p_state),
        .score      (p_score),
        .hi_score   (p_hi)
    );

    // Reference model: phase rules applied once per clock on sampled inputs.
    int m_phase, m_score, m_hi, m_frames;
    bit m_pend, m_tick, m_rst, m_run, m_flap;
    bit vs_hist [2];
    bit key_hist [2];
    bit t_now, p_now;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_phase = 0; m_score = 0; m_hi = 0; m_frames = 0;
            m_pend = 0; m_tick = 0; m_rst = 0; m_run = 0; m_flap = 0;
            vs_hist[0] = 0; vs_hist[1] = 0;
            key_hist[0] = 0; key_hist[1] = 0;
        end else begin
            t_now = vs_hist[0] && !vs_hist[1];
            p_now = key_hist[0] && !key_hist[1];
            vs_hist[1] = vs_hist[0];
            vs_hist[0] = !vsync;
            key_hist[1] = key_hist[0];
            key_hist[0] = key_press;
            m_tick = t_now;
            m_rst = 0;
            m_flap = 0;
            case (m_phase)
                0, 4: if (p_now) begin
                    m_phase = 1; m_rst = 1; m_score = 0; m_frames = 0;
                end
                1: if (t_now) begin
                    m_frames++;
                    if (m_frames == RF) begin
                        m_phase = 2; m_pend = 0;
                    end
                end
                2: if (collision) begin
                    m_phase = 3; m_pend = 0; m_frames = 0;
                    if (m_score > m_hi) m_hi = m_score;
                end else begin
                    if (pipe_pass) m_score = (m_score + 1 > SM) ? SM : m_score + 1;
                    if (t_now) begin
                        m_flap = m_pend || p_now;
                        m_pend = 0;
                    end else if (p_now) begin
                        m_pend = 1;
                    end
                end
                3: if (t_now) begin
                    m_frames++;
                    if (m_frames == HF) m_phase = 4;
                end
                default: m_phase = 0;
            endcase
            m_run = (m_phase == 2);
        end
    end

    // Free-running vsync: active-low pulse of 2 clocks at frame start.
    initial begin
        forever begin
            int len;
            len = frame_len;
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                vsync = (i < 2) ? 1'b0 : 1'b1;
                if (i == 0) act_cyc = cyc;
            end
        end
    end

    task automatic pulse_key();
        key_press = 1'b1;
        @(negedge clk);
        key_press = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget,
                              output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (state == tgt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        bit bad;
        n_cmp++;
        if (state !== 3'd0 || score !== 7'd0 || hi_score !== 7'd0 ||
            {frame_tick, world_rst, world_run, flap} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_init: state=%0d score=%0d hi=%0d pulses=%b expected all 0",
                     state, score, hi_score, {frame_tick, world_rst, world_run, flap});
        end
        rst_n = 1'b1;
        @(negedge clk);
        pulse_key();
        wait_state(3'd2, 2000, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL reset_reach_play: state=%0d expected 2", state);
        end
        repeat (5) begin
            pipe_pass = 1'b1; @(negedge clk);
            pipe_pass = 1'b0; @(negedge clk);
        end
        n_cmp++;
        if (score !== 7'd5) begin
            n_bad++;
            $display("FAIL reset_pre_score: score=%0d expected 5", score);
        end
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (state !== 3'd0 || score !== 7'd0 || hi_score !== 7'd0 ||
                {frame_tick, world_rst, world_run, flap} !== 4'b0) begin
                n_bad++;
                $display("FAIL reset_mid_play: state=%0d score=%0d hi=%0d pulses=%b expected all 0",
                         state, score, hi_score, {frame_tick, world_rst, world_run, flap});
            end
        end
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (state !== 3'd0 || world_rst !== 1'b0 || world_run !== 1'b0)
                bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL reset_release: state=%0d world_rst=%b world_run=%b expected idle",
                     state, world_rst, world_run);
        end
    endtask

    task automatic test_start();
        int wr = 0;
        int ticks = 0;
        bit first_ok = 1'b0;
        bit seen = 1'b0;
        bit ok = 1'b0;
        logic [2:0] prev;
        prev = state;
        key_press = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (i == 0) key_press = 1'b0;
            if (world_rst) begin
                wr++;
                if (!seen) first_ok = (state == 3'd1);
                seen = 1'b1;
            end
            if (frame_tick && prev == 3'd1) ticks++;
            if (state == 3'd2) begin
                ok = 1'b1;
                break;
            end
            prev = state;
        end
        n_cmp++;
        if (wr != 1 || !first_ok) begin
            n_bad++;
            $display("FAIL start_world_rst: pulses=%0d with_ready=%b expected 1 and 1",
                     wr, first_ok);
        end
        n_cmp++;
        if (!ok || ticks != RF || world_run !== 1'b1) begin
            n_bad++;
            $display("FAIL start_ready_len: reached=%b ticks=%0d run=%b expected 1 %0d 1",
                     ok, ticks, world_run, RF);
        end
    endtask

    task automatic test_score_collide();
        repeat (10) begin
            pipe_pass = 1'b1; @(negedge clk);
            pipe_pass = 1'b0; @(negedge clk);
        end
        n_cmp++;
        if (score !== 7'd10 || score !== 7'(m_score)) begin
            n_bad++;
            $display("FAIL score_ten: score=%0d expected 10 (model %0d)", score, m_score);
        end
        collision = 1'b1;
        pipe_pass = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        pipe_pass = 1'b0;
        n_cmp++;
        if (state !== 3'd3 || score !== 7'd10 || hi_score !== 7'd10 ||
            world_run !== 1'b0) begin
            n_bad++;
            $display("FAIL collide_wins: state=%0d score=%0d hi=%0d run=%b expected 3 10 10 0",
                     state, score, hi_score, world_run);
        end
    endtask

    task automatic test_restart();
        int ticks = 0;
        int wr = 0;
        bit bad = 1'b0;
        bit ok = 1'b0;
        logic [2:0] prev;
        prev = state;
        for (int i = 0; i < 3000; i++) begin
            key_press = (ticks < HF - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (frame_tick && prev == 3'd3) ticks++;
            if (state !== 3'(m_phase) || world_rst !== 1'b0 ||
                flap !== 1'b0 || world_run !== 1'b0)
                bad = 1'b1;
            if (state == 3'd4) begin
                ok = 1'b1;
                break;
            end
            prev = state;
        end
        key_press = 1'b0;
        n_cmp++;
        if (!ok || bad || ticks != HF) begin
            n_bad++;
            $display("FAIL dead_hold: over=%b disturbed=%b ticks=%0d expected 1 0 %0d",
                     ok, bad, ticks, HF);
        end
        repeat (5) @(negedge clk);
        key_press = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            key_press = 1'b0;
            if (world_rst) begin
                wr++;
                if (state !== 3'd1) bad = 1'b1;
            end
        end
        n_cmp++;
        if (wr != 1 || bad || state !== 3'd1 || score !== 7'd0 ||
            hi_score !== 7'd10) begin
            n_bad++;
            $display("FAIL restart: rst_pulses=%0d state=%0d score=%0d hi=%0d expected 1 1 0 10",
                     wr, state, score, hi_score);
        end
    endtask

    task automatic test_flap();
        int n_press;
        int flaps = 0;
        int ticks = 0;
        bit ok = 1'b0;
        bit bad = 1'b0;
        for (int i = 0; i < 100 && !frame_tick; i++) @(negedge clk);
        n_press = $urandom_range(2, 4);
        repeat (n_press) pulse_key();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (flap) begin
                flaps++;
                if (!frame_tick) bad = 1'b1;
            end
            if (flap !== m_flap) bad = 1'b1;
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok || bad || flaps != 1) begin
            n_bad++;
            $display("FAIL flap_multi: presses=%0d flaps=%0d misaligned=%b tick=%b expected 1 0 1",
                     n_press, flaps, bad, ok);
        end
        flaps = 0;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_tick) break;
        end
        key_press = 1'b1;
        for (int i = 0; i < 400 && ticks < 6; i++) begin
            @(negedge clk);
            if (flap) begin
                flaps++;
                if (!frame_tick) bad = 1'b1;
            end
            if (frame_tick) ticks++;
            if (ticks == 5) key_press = 1'b0;
        end
        key_press = 1'b0;
        n_cmp++;
        if (flaps != 1 || bad || ticks != 6) begin
            n_bad++;
            $display("FAIL flap_held: flaps=%0d misaligned=%b ticks=%0d expected 1 0 6",
                     flaps, bad, ticks);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            key_press = ($urandom_range(0, 5) == 0);
            pipe_pass = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            n_cmp++;
            if (flap !== m_flap || frame_tick !== m_tick ||
                score !== 7'(m_score) || state !== 3'(m_phase) ||
                world_run !== m_run || world_rst !== m_rst) begin
                n_bad++;
                errs++;
                if (errs < 5)
                    $display("FAIL random_play: flap=%b tick=%b score=%0d state=%0d run=%b expected %b %b %0d %0d %b",
                             flap, frame_tick, score, state, world_run,
                             m_flap, m_tick, m_score, m_phase, m_run);
            end
        end
        key_press = 1'b0;
        pipe_pass = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_saturate();
        repeat (105) begin
            pipe_pass = 1'b1; @(negedge clk);
            pipe_pass = 1'b0; @(negedge clk);
        end
        n_cmp++;
        if (score !== 7'd99 || state !== 3'd2) begin
            n_bad++;
            $display("FAIL score_sat: score=%0d state=%0d expected 99 2", score, state);
        end
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        n_cmp++;
        if (state !== 3'd3 || hi_score !== 7'd99 || hi_score !== 7'(m_hi)) begin
            n_bad++;
            $display("FAIL hi_update: state=%0d hi=%0d expected 3 99", state, hi_score);
        end
    endtask

    task automatic test_polarity();
        int old;
        int seen = 0;
        frame_len = 800;
        old = act_cyc;
        for (int i = 0; i < 2000 && seen < 2; i++) begin
            @(negedge clk);
            if (act_cyc != old) begin
                seen++;
                old = act_cyc;
            end
        end
        n_cmp++;
        if (seen != 2) begin
            n_bad++;
            $display("FAIL pol_sync: frames_seen=%0d expected 2", seen);
        end
        for (int f = 0; f < 3; f++) begin
            int c_lo = 0;
            int c_hi = 0;
            int d_lo = -1;
            int d_hi = -1;
            for (int i = 0; i < 800; i++) begin
                @(negedge clk);
                if (frame_tick) begin
                    c_lo++;
                    d_lo = cyc - act_cyc;
                end
                if (p_tick) begin
                    c_hi++;
                    d_hi = cyc - act_cyc;
                end
            end
            n_cmp++;
            if (c_lo != 1 || c_hi != 1 || d_lo != 2 || d_hi != 2) begin
                n_bad++;
                $display("FAIL polarity: frame=%0d ticks_low=%0d ticks_high=%0d lat_low=%0d lat_high=%0d expected 1 1 2 2",
                         f, c_lo, c_hi, d_lo, d_hi);
            end
        end
    endtask

    initial begin
        bit ok;
        repeat (3) @(negedge clk);
        test_reset();
        test_start();
        test_score_collide();
        test_restart();
        wait_state(3'd2, 2000, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL replay_reach_play: state=%0d expected 2", state);
        end
        test_flap();
        test_random();
        test_saturate();
        test_polarity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
